// File: rtl/input_bridge_pkg.sv
// Shared constants for the debounced input bridge: register word
// addresses and the position of the switch-change pending bit.
package input_bridge_pkg;

   localparam logic [2:0] ADDR_SW_LO    = 3'd0;
   localparam logic [2:0] ADDR_SW_HI    = 3'd1;
   localparam logic [2:0] ADDR_KEY      = 3'd2;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
   localparam logic [2:0] ADDR_IRQ_PEND = 3'd4;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;

   // Pending/mask bit that collects "any switch changed" events.
   localparam int PEND_SW_BIT = 31;

endpackage

// File: rtl/input_bridge_ctrl_if.sv
// Zero-wait-state register bus between the CPU bridge and the input
// peripheral: word address, write strobe/data and combinational read data.
interface input_bridge_ctrl_if;

   logic [2:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/debounce_chan.sv
// One input channel: 2-flop synchroniser followed by a debounce counter.
// A new level is accepted only after DEB_CYCLES consecutive cycles of
// disagreement with the current stable level; rise/fall pulse for exactly
// the cycle whose clock edge updates `stable`.
module debounce_chan #(
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
   input  logic clk_in,
   input  logic sys_rstn,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   // Synchroniser, stable level and counter; idle pins are high.
   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values;
         // with blocking ones the two sync stages would collapse into one.
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Debounce decision: accept, count the disagreement, or restart.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      stable_d = stable_q;
      cnt_d    = '0;
      accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
      if (accept) begin
         stable_d = sync2_q;
      end else if (sync2_q != stable_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign stable = stable_q;
   assign rise   = accept &  sync2_q;
   assign fall   = accept & ~sync2_q;

endmodule

// File: rtl/input_bridge_ctrl.sv
// Debounced DIP-switch / user-key peripheral. Debounces every raw pin,
// reports active-high levels, and raises a maskable level interrupt on
// selected key edges and on any switch change.
module input_bridge_ctrl
   import input_bridge_pkg::*;
#(
   parameter int NUM_BANKS  = 8,
   parameter int KEY_W      = 8,
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
   input  logic                   clk_in,
   input  logic                   sys_rstn,
   input  logic [NUM_BANKS*8-1:0] dip_switch,
   input  logic [KEY_W-1:0]       user_key,
   input_bridge_ctrl_if.slave     bus,
   output logic                   irq
);

   localparam int          NUM_SW       = NUM_BANKS * 8;
   localparam logic [31:0] KEY_BITS     = 32'((64'd1 << KEY_W) - 64'd1);
   localparam logic [31:0] MASK_WR_BITS = KEY_BITS | (32'd1 << PEND_SW_BIT);

   logic [NUM_SW-1:0] sw_stable, sw_rise, sw_fall;
   logic [KEY_W-1:0]  key_stable, key_rise, key_fall;
   logic [63:0]       sw_pad;

   logic [31:0]       mask_q, mask_d;
   logic [31:0]       pend_q, pend_d, pend_set;
   logic [KEY_W-1:0]  edge_sel_q, edge_sel_d;
   logic              irq_q, irq_d;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan (
         .clk_in  (clk_in),
         .sys_rstn(sys_rstn),
         .raw     (dip_switch[i]),
         .stable  (sw_stable[i]),
         .rise    (sw_rise[i]),
         .fall    (sw_fall[i])
      );
   end

   for (genvar i = 0; i < KEY_W; i++) begin : g_key
      debounce_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan (
         .clk_in  (clk_in),
         .sys_rstn(sys_rstn),
         .raw     (user_key[i]),
         .stable  (key_stable[i]),
         .rise    (key_rise[i]),
         .fall    (key_fall[i])
      );
   end

   // Set events: a press is a falling stable level (pins are active-low).
   always_comb begin
      pend_set = '0;
      for (int i = 0; i < KEY_W; i++) begin
         pend_set[i] = edge_sel_q[i] ? key_fall[i] : key_rise[i];
      end
      pend_set[PEND_SW_BIT] = |{sw_rise, sw_fall};
   end

   // Register writes; a set event in the same cycle beats a W1C clear.
   always_comb begin
      mask_d     = mask_q;
      edge_sel_d = edge_sel_q;
      pend_d     = pend_q | pend_set;
      irq_d      = |(pend_q & mask_q);
      if (bus.we) begin
         case (bus.addr)
            ADDR_IRQ_MASK: mask_d     = bus.wdata & MASK_WR_BITS;
            ADDR_IRQ_PEND: pend_d     = (pend_q & ~bus.wdata) | pend_set;
            ADDR_EDGE_SEL: edge_sel_d = bus.wdata[KEY_W-1:0];
            default:       ;
         endcase
      end
   end

   // Register file and registered interrupt output.
   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         mask_q     <= '0;
         pend_q     <= '0;
         edge_sel_q <= '1;
         irq_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         edge_sel_q <= edge_sel_d;
         irq_q      <= irq_d;
      end
   end

   // Active-high switch levels, zero-padded to the full 8-bank map.
   always_comb begin
      sw_pad             = '0;
      sw_pad[NUM_SW-1:0] = ~sw_stable;
   end

   // Combinational read mux.
   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         ADDR_SW_LO:    bus.rdata             = sw_pad[31:0];
         ADDR_SW_HI:    bus.rdata             = sw_pad[63:32];
         ADDR_KEY:      bus.rdata[KEY_W-1:0]  = ~key_stable;
         ADDR_IRQ_MASK: bus.rdata             = mask_q;
         ADDR_IRQ_PEND: bus.rdata             = pend_q;
         ADDR_EDGE_SEL: bus.rdata[KEY_W-1:0]  = edge_sel_q;
         default:       ;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_input_bridge_ctrl.sv
// Self-checking bench for input_bridge_ctrl with DEB_CYCLES=4, 8 banks,
// 8 keys: a vector table for read-back of switch/key levels plus
// hand-written sequences for interrupt timing, glitches, W1C collision
// and asynchronous reset.
module tb_input_bridge_ctrl;
   import input_bridge_pkg::*;

   localparam int NUM_BANKS  = 8;
   localparam int KEY_W      = 8;
   localparam int DEB_CYCLES = 4;
   localparam int SETTLE     = DEB_CYCLES + 2;

   logic                   clk_in;
   logic                   sys_rstn;
   logic [NUM_BANKS*8-1:0] dip_switch;
   logic [KEY_W-1:0]       user_key;
   logic                   irq;

   input_bridge_ctrl_if bus();

   input_bridge_ctrl #(
      .NUM_BANKS (NUM_BANKS),
      .KEY_W     (KEY_W),
      .DEB_CYCLES(DEB_CYCLES)
   ) dut (
      .clk_in    (clk_in),
      .sys_rstn  (sys_rstn),
      .dip_switch(dip_switch),
      .user_key  (user_key),
      .bus       (bus.slave),
      .irq       (irq)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      string       name;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [63:0] dip;
      logic [7:0]  key;
      logic [31:0] sw_lo;
      logic [31:0] sw_hi;
      logic [31:0] key_rd;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      @(negedge clk_in);
      bus.we    = 1'b0;
   endtask

   task automatic expect_reg(input logic [2:0] a, input logic [31:0] d, input string name);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] rd;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         bus_read(e.addr, rd);
         check(e.name, rd, e.data);
      end
   endtask

   task automatic check_irq(input string name, input logic exp);
      check(name, {31'b0, irq}, {31'b0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{dip: 64'hFFFFFF36_FFFFFF87, key: 8'hFF,
                  sw_lo: 32'h0000_0078, sw_hi: 32'h0000_00C9, key_rd: 32'h00};
      vecs[1] = '{dip: 64'h00FFFFFF_FFFFFF00, key: 8'hF0,
                  sw_lo: 32'h0000_00FF, sw_hi: 32'hFF00_0000, key_rd: 32'h0F};
      vecs[2] = '{dip: 64'h12345678_9ABCDEF0, key: 8'h7E,
                  sw_lo: 32'h6543_210F, sw_hi: 32'hEDCB_A987, key_rd: 32'h81};
      vecs[3] = '{dip: 64'hFFFFFFFF_FFFFFFFF, key: 8'hFF,
                  sw_lo: 32'h0, sw_hi: 32'h0, key_rd: 32'h0};

      sys_rstn   = 1'b0;
      dip_switch = '1;
      user_key   = '1;
      bus.addr   = '0;
      bus.we     = 1'b0;
      bus.wdata  = '0;

      // Reset state
      tick(3);
      expect_reg(ADDR_KEY,      32'h0,  "rst_key");
      expect_reg(ADDR_IRQ_PEND, 32'h0,  "rst_pend");
      expect_reg(ADDR_SW_LO,    32'h0,  "rst_sw_lo");
      expect_reg(ADDR_EDGE_SEL, 32'hFF, "rst_edge_sel");
      drain();
      expect_reg(ADDR_IRQ_MASK, 32'h0,  "rst_mask");
      drain();
      check_irq("rst_irq", 1'b0);
      sys_rstn = 1'b1;
      tick(2);

      // Table: level read-back after full debounce latency, mask still 0
      for (int i = 0; i < 4; i++) begin
         dip_switch = vecs[i].dip;
         user_key   = vecs[i].key;
         expect_reg(ADDR_SW_LO, vecs[i].sw_lo,  $sformatf("tbl%0d_sw_lo", i));
         expect_reg(ADDR_SW_HI, vecs[i].sw_hi,  $sformatf("tbl%0d_sw_hi", i));
         expect_reg(ADDR_KEY,   vecs[i].key_rd, $sformatf("tbl%0d_key", i));
         tick(SETTLE);
         drain();
         check_irq($sformatf("tbl%0d_irq", i), 1'b0);
      end
      // presses of keys 0-3 (row 1), key 7 (row 2), and switch changes
      expect_reg(ADDR_IRQ_PEND, 32'h8000_008F, "tbl_pend");
      drain();
      bus_write(ADDR_IRQ_PEND, 32'hFFFF_FFFF);
      expect_reg(ADDR_IRQ_PEND, 32'h0, "w1c_all");
      drain();

      // Register access: writable bits, ignored addresses
      bus_write(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
      expect_reg(ADDR_IRQ_MASK, 32'h8000_00FF, "mask_wr_bits");
      drain();
      bus_write(3'd6, 32'hDEAD_BEEF);
      bus_write(ADDR_KEY, 32'hFFFF_FFFF);
      expect_reg(3'd6,     32'h0, "addr6_read");
      expect_reg(ADDR_KEY, 32'h0, "key_wr_ignored");
      drain();
      bus_write(ADDR_IRQ_MASK, 32'h0000_0001);
      expect_reg(ADDR_IRQ_MASK, 32'h1, "mask_set_1");
      drain();

      // Press interrupt on key 0
      user_key = 8'hFE;
      tick(SETTLE - 1);
      expect_reg(ADDR_IRQ_PEND, 32'h0, "press_pend_edge5");
      drain();
      tick(1);
      expect_reg(ADDR_IRQ_PEND, 32'h1, "press_pend_edge6");
      drain();
      check_irq("press_irq_edge6", 1'b0);
      tick(1);
      check_irq("press_irq_edge7", 1'b1);
      bus_write(ADDR_IRQ_PEND, 32'h1);
      check_irq("w1c_irq_write_edge", 1'b1);
      expect_reg(ADDR_IRQ_PEND, 32'h0, "w1c_pend");
      drain();
      tick(1);
      check_irq("w1c_irq_after", 1'b0);
      user_key = 8'hFF;
      tick(SETTLE + 1);
      expect_reg(ADDR_IRQ_PEND, 32'h0, "release_ignored");
      expect_reg(ADDR_KEY,      32'h0, "release_key");
      drain();

      // Glitch rejection: key 3 low for 3 cycles
      user_key = 8'hF7;
      tick(3);
      user_key = 8'hFF;
      tick(8);
      expect_reg(ADDR_KEY,      32'h0, "glitch_key");
      expect_reg(ADDR_IRQ_PEND, 32'h0, "glitch_pend");
      drain();

      // Release-edge interrupt on key 6
      bus_write(ADDR_EDGE_SEL, 32'hFFFF_FFBF);
      bus_write(ADDR_IRQ_MASK, 32'h0000_0040);
      expect_reg(ADDR_EDGE_SEL, 32'hBF, "edge_sel_rd");
      drain();
      user_key = 8'hBF;
      tick(SETTLE);
      expect_reg(ADDR_KEY,      32'h40, "rel_pressed_key");
      expect_reg(ADDR_IRQ_PEND, 32'h0,  "rel_press_no_pend");
      drain();
      user_key = 8'hFF;
      tick(SETTLE - 1);
      expect_reg(ADDR_IRQ_PEND, 32'h0, "rel_pend_edge5");
      drain();
      tick(1);
      expect_reg(ADDR_IRQ_PEND, 32'h40, "rel_pend_edge6");
      drain();
      tick(1);
      check_irq("rel_irq", 1'b1);
      bus_write(ADDR_IRQ_PEND, 32'h40);
      tick(1);
      check_irq("rel_irq_cleared", 1'b0);
      bus_write(ADDR_EDGE_SEL, 32'hFF);
      bus_write(ADDR_IRQ_MASK, 32'h1);

      // Collision: W1C write edge coincides with the PEND[0] set edge
      user_key = 8'hFE;
      tick(SETTLE - 1);
      bus_write(ADDR_IRQ_PEND, 32'h1);
      expect_reg(ADDR_IRQ_PEND, 32'h1, "collision_set_wins");
      drain();
      tick(1);
      check_irq("collision_irq", 1'b1);
      user_key = 8'hFF;
      tick(SETTLE + 1);
      bus_write(ADDR_IRQ_PEND, 32'h1);
      tick(1);
      check_irq("collision_cleared", 1'b0);

      // Async reset in the middle of a key 2 debounce (key held)
      user_key = 8'hFB;
      tick(4);
      #2 sys_rstn = 1'b0;
      expect_reg(ADDR_IRQ_MASK, 32'h0, "arst_mask");
      expect_reg(ADDR_KEY,      32'h0, "arst_key");
      drain();
      sys_rstn = 1'b1;
      tick(2);
      expect_reg(ADDR_KEY,      32'h0, "arst_edge2_key");
      expect_reg(ADDR_IRQ_PEND, 32'h0, "arst_edge2_pend");
      drain();
      tick(SETTLE - 3);
      expect_reg(ADDR_KEY,      32'h0, "arst_edge5_key");
      drain();
      tick(1);
      expect_reg(ADDR_KEY,      32'h04, "arst_edge6_key");
      expect_reg(ADDR_IRQ_PEND, 32'h04, "arst_edge6_pend");
      drain();
      tick(1);
      check_irq("arst_irq_masked", 1'b0);
      user_key = 8'hFF;
      tick(SETTLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
